// File: rtl/sha_job_ctrl_if.sv
// Job, result and hasher-side signals of sha_job_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface sha_job_ctrl_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HASH_W = 256;

  logic              job_valid;
  logic              job_ready;
  logic [HASH_W-1:0] job_midstate;
  logic [HASH_W-1:0] job_digest_in;
  logic [WORD_W-1:0] job_merkle;
  logic [WORD_W-1:0] job_time;
  logic [WORD_W-1:0] job_target;
  logic [WORD_W-1:0] job_nonce;
  logic [WORD_W-1:0] job_count;
  logic              abort;

  logic              hash_rst_n;
  logic              hash_write_en;
  logic [HASH_W-1:0] hash_digest_initial;
  logic [HASH_W-1:0] hash_digest_in;
  logic [WORD_W-1:0] hash_merkle;
  logic [WORD_W-1:0] hash_time;
  logic [WORD_W-1:0] hash_target;
  logic [WORD_W-1:0] hash_nonce;
  logic              hash_valid_i;
  logic [WORD_W-1:0] hash_time_i;
  logic [WORD_W-1:0] hash_nonce_i;
  logic [HASH_W-1:0] hash_result_i;

  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_status;
  logic [WORD_W-1:0] res_time;
  logic [WORD_W-1:0] res_nonce;
  logic [HASH_W-1:0] res_hash;
  logic              busy;

  modport slave (
    input  job_valid, job_midstate, job_digest_in, job_merkle, job_time,
           job_target, job_nonce, job_count, abort,
           hash_valid_i, hash_time_i, hash_nonce_i, hash_result_i, res_ready,
    output job_ready, hash_rst_n, hash_write_en, hash_digest_initial,
           hash_digest_in, hash_merkle, hash_time, hash_target, hash_nonce,
           res_valid, res_status, res_time, res_nonce, res_hash, busy
  );

  modport master (
    output job_valid, job_midstate, job_digest_in, job_merkle, job_time,
           job_target, job_nonce, job_count, abort,
           hash_valid_i, hash_time_i, hash_nonce_i, hash_result_i, res_ready,
    input  job_ready, hash_rst_n, hash_write_en, hash_digest_initial,
           hash_digest_in, hash_merkle, hash_time, hash_target, hash_nonce,
           res_valid, res_status, res_time, res_nonce, res_hash, busy
  );
endinterface

// File: rtl/sha_job_ctrl.sv
// Sequences one sha_hasher through a job: load start values under reset,
// run for count + pipeline latency cycles, then report exactly one result.
module sha_job_ctrl #(
  parameter int unsigned PIPE_LAT   = 131,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  sha_job_ctrl_if.slave   bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned RUN_W  = 33;
  localparam int unsigned LD_W   = 4;
  localparam logic [1:0]  ST_EXHAUST = 2'b00;
  localparam logic [1:0]  ST_FOUND   = 2'b01;
  localparam logic [1:0]  ST_ABORT   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REPORT} state_e;

  state_e            state_q, state_d;
  logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0]  run_last;
  logic              job_ready_q, job_ready_d;
  logic              busy_q, busy_d;
  logic              hash_rst_n_q, hash_rst_n_d;
  logic              hash_we_q, hash_we_d;
  logic [HASH_W-1:0] digest_init_q, digest_init_d;
  logic [HASH_W-1:0] digest_in_q, digest_in_d;
  logic [WORD_W-1:0] merkle_q, merkle_d;
  logic [WORD_W-1:0] time_q, time_d;
  logic [WORD_W-1:0] target_q, target_d;
  logic [WORD_W-1:0] nonce_q, nonce_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_status_q, res_status_d;
  logic [WORD_W-1:0] res_time_q, res_time_d;
  logic [WORD_W-1:0] res_nonce_q, res_nonce_d;
  logic [HASH_W-1:0] res_hash_q, res_hash_d;

  // Last run_cnt value; 33 bits so count = 0xFFFFFFFF cannot wrap.
  assign run_last = RUN_W'(count_q) + RUN_W'(PIPE_LAT) - RUN_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    run_cnt_d     = run_cnt_q;
    digest_init_d = digest_init_q;
    digest_in_d   = digest_in_q;
    merkle_d      = merkle_q;
    time_d        = time_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    count_d       = count_q;
    res_status_d  = res_status_q;
    res_time_d    = res_time_q;
    res_nonce_d   = res_nonce_q;
    res_hash_d    = res_hash_q;

    case (state_q)
      S_IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          digest_init_d = bus.job_midstate;
          digest_in_d   = bus.job_digest_in;
          merkle_d      = bus.job_merkle;
          time_d        = bus.job_time;
          target_d      = bus.job_target;
          nonce_d       = bus.job_nonce;
          count_d       = bus.job_count;
          ld_cnt_d      = '0;
          res_status_d  = ST_EXHAUST;
          res_time_d    = '0;
          res_nonce_d   = '0;
          res_hash_d    = '0;
          state_d       = (bus.job_count == '0) ? S_REPORT : S_LOAD;
        end
      end
      S_LOAD: begin
        run_cnt_d = '0;
        if (ld_cnt_q == LD_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          ld_cnt_d = ld_cnt_q + LD_W'(1);
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        if (bus.abort) begin
          res_status_d = ST_ABORT;
          state_d      = S_REPORT;
        end else if (bus.hash_valid_i) begin
          res_status_d = ST_FOUND;
          res_time_d   = bus.hash_time_i;
          res_nonce_d  = bus.hash_nonce_i;
          res_hash_d   = bus.hash_result_i;
          state_d      = S_REPORT;
        end else if (run_cnt_q == run_last) begin
          res_status_d = ST_EXHAUST;
          state_d      = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    job_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
    hash_rst_n_d = (state_d != S_LOAD);
    hash_we_d    = (state_d == S_RUN);
    res_valid_d  = (state_d == S_REPORT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      ld_cnt_q      <= '0;
      run_cnt_q     <= '0;
      job_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      hash_rst_n_q  <= 1'b0;
      hash_we_q     <= 1'b0;
      digest_init_q <= '0;
      digest_in_q   <= '0;
      merkle_q      <= '0;
      time_q        <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      count_q       <= '0;
      res_valid_q   <= 1'b0;
      res_status_q  <= ST_EXHAUST;
      res_time_q    <= '0;
      res_nonce_q   <= '0;
      res_hash_q    <= '0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      run_cnt_q     <= run_cnt_d;
      job_ready_q   <= job_ready_d;
      busy_q        <= busy_d;
      hash_rst_n_q  <= hash_rst_n_d;
      hash_we_q     <= hash_we_d;
      digest_init_q <= digest_init_d;
      digest_in_q   <= digest_in_d;
      merkle_q      <= merkle_d;
      time_q        <= time_d;
      target_q      <= target_d;
      nonce_q       <= nonce_d;
      count_q       <= count_d;
      res_valid_q   <= res_valid_d;
      res_status_q  <= res_status_d;
      res_time_q    <= res_time_d;
      res_nonce_q   <= res_nonce_d;
      res_hash_q    <= res_hash_d;
    end
  end

  assign bus.job_ready           = job_ready_q;
  assign bus.busy                = busy_q;
  assign bus.hash_rst_n          = hash_rst_n_q;
  assign bus.hash_write_en       = hash_we_q;
  assign bus.hash_digest_initial = digest_init_q;
  assign bus.hash_digest_in      = digest_in_q;
  assign bus.hash_merkle         = merkle_q;
  assign bus.hash_time           = time_q;
  assign bus.hash_target         = target_q;
  assign bus.hash_nonce          = nonce_q;
  assign bus.res_valid           = res_valid_q;
  assign bus.res_status          = res_status_q;
  assign bus.res_time            = res_time_q;
  assign bus.res_nonce           = res_nonce_q;
  assign bus.res_hash            = res_hash_q;
endmodule

// File: doc/sha_job_ctrl.md
Name: sha_job_ctrl

Overview:
- Sequences one `sha_hasher` instance through complete mining jobs.
- Accepts a job over a valid/ready handshake and holds its fields stable for the whole job. Resets the hasher to load the nonce/time start values, then enables it for a bounded number of cycles.
- Captures the solution if the hasher reports one.
- Reports exactly one result per job (found / exhausted / aborted) over a valid/ready handshake.

Parameters:
- PIPE_LAT, 131, cycles from the first hasher write-enable until the first candidate reaches the comparator; added to the enable window so the last nonce is checked.
- RST_CYCLES, 2, cycles `hash_rst_n` is held low in LOAD; legal range 1..15.

Ports:
- CLK  input  1  single clock; all logic on posedge.
- RST  input  1  asynchronous active-low reset.
- job_valid  input  1  job offered.
- job_ready  output  1  controller can accept a job (IDLE only).
- job_midstate  input  256  forwarded to the hasher `digest_intial` input.
- job_digest_in  input  256  forwarded to the hasher `digest_in` input.
- job_merkle, job_time, job_target, job_nonce  input  32 each  block fields; time/nonce are the start values.
- job_count  input  32  number of nonces to try.
- abort  input  1  terminate the current job.
- hash_rst_n  output  1  drives the hasher `RST`.
- hash_write_en  output  1  drives the hasher `write_en`.
- hash_digest_initial, hash_digest_in  output  256 each  registered job copies.
- hash_merkle, hash_time, hash_target, hash_nonce  output  32 each  registered job copies.
- hash_valid_i  input  1  hasher `valid_out`.
- hash_time_i, hash_nonce_i  input  32 each  hasher `time_out`/`nonce_out`.
- hash_result_i  input  256  hasher `result_out`.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed.
- res_status  output  2  00 = exhausted, 01 = found, 10 = aborted.
- res_time, res_nonce  output  32 each  captured solution; 0 unless found.
- res_hash  output  256  captured hash; 0 unless found.
- busy  output  1  state is LOAD or RUN.

Behaviour:
- Reset (RST = 0), all outputs:
  - job_ready = 0, busy = 0, hash_write_en = 0, hash_rst_n = 0.
  - res_valid = 0, res_status = 00, res_* = 0, hash_* field outputs = 0.
  - State = IDLE.
  - A reset asserted mid-job discards the job with no result.
- IDLE:
  - job_ready = 1, hash_rst_n = 1, hash_write_en = 0.
  - On job_valid & job_ready, all job_* fields are registered into the hash_* outputs.
  - job_count = 0 goes directly to REPORT with status 00 on the next cycle.
  - Any other count goes to LOAD.
- LOAD:
  - hash_rst_n = 0 for exactly RST_CYCLES cycles, then RUN.
  - hash_* fields are stable throughout LOAD, so the hasher samples the start time/nonce.
  - run_cnt (33-bit) is cleared to 0.
- RUN:
  - hash_rst_n = 1 and hash_write_en = 1 every cycle; run_cnt increments each cycle.
  - Exit priority, evaluated on each RUN edge:
    1. abort = 1 → REPORT, status 10.
    2. hash_valid_i = 1 → capture hash_time_i, hash_nonce_i and hash_result_i into res_*; REPORT, status 01.
    3. run_cnt == job_count + PIPE_LAT − 1 (33-bit compare, no overflow for job_count = 0xFFFFFFFF) → REPORT, status 00.
  - hash_write_en is 0 from the first REPORT cycle, so the hasher freezes.
- REPORT:
  - res_valid = 1; res_* and res_status held stable while res_ready = 0.
  - On res_valid & res_ready → IDLE; res_valid drops the next cycle.
  - hash_* fields are held until the next job is accepted.
  - abort is ignored in IDLE and REPORT.
- Job timing:
  - Minimum job-to-job spacing is one IDLE cycle.
  - Total job latency from job handshake to res_valid, if not found/aborted: 1 + RST_CYCLES + job_count + PIPE_LAT cycles.

Test Plan:
1. Reset: hold RST = 0 with job_valid = 1 → job_ready = 0, hash_rst_n = 0, res_valid = 0. One cycle after release: job_ready = 1, hash_rst_n = 1.
2. Exhaust: PIPE_LAT = 4, RST_CYCLES = 2, hasher stub never valid, job_count = 10, job_nonce = 0x100.
   - hash_rst_n is low exactly 2 cycles with hash_nonce = 0x100.
   - hash_write_en is high exactly 14 cycles.
   - res_status = 00, res_nonce = 0.
   - res_valid is stable through 5 cycles of res_ready = 0.
3. Found: stub asserts hash_valid_i on the 7th RUN cycle with nonce 0x1234, time 0x5A5A5A5A, result 0xABCD… → hash_write_en is 0 on the next cycle, res_status = 01, res_nonce = 0x1234, res_hash matches.
4. Simultaneous events:
   - hash_valid_i on the final (14th) RUN cycle → status 01.
   - abort and hash_valid_i in the same cycle → status 10, res_nonce = 0.
5. Abort and zero count:
   - abort on RUN cycle 3 → status 10, exactly 3 write-enable cycles.
   - abort in IDLE → no effect.
   - job_count = 0 → no LOAD, no write_en, status 00 one cycle after the handshake.
6. Back-to-back: two queued jobs with res_ready tied high → second job_ready exactly one cycle after the first res_valid handshake; fields switch only on the second job's acceptance.
